mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Eight-way round-robin arbiter with a shared, burst-limited data mux.
// A grant is held while the granted requester keeps req high, up to MAX_BURST
// beats. The grant is released when req drops or when the last allowed beat is
// taken. On release the priority pointer moves one past the released requester.
// A new winner is then picked in the same cycle, so back-to-back grants have no
// idle cycle between them.
//
// Ports
//   clk    : single clock, rising edge
//   rst_n  : synchronous reset, active low
//   req    : [7:0] per-requester "beat available"
//   din    : [8*DW-1:0] requester data, requester i in bits [i*DW +: DW]
//   sel    : [2:0] registered index of current / last granted requester
//   gnt    : [7:0] registered one-hot grant, zero when idle
//   dout   : [DW-1:0] din slice selected by sel (always, including idle)
//   valid  : dout carries an accepted beat this cycle
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      req,
    input  logic [8*DW-1:0] din,
    output logic [2:0]      sel,
    output logic [7:0]      gnt,
    output logic [DW-1:0]   dout,
    output logic            valid
);

    // Counter holds the number of beats already taken in the current grant.
    // It only ever reaches MAX_BURST-1 before the grant is released or renewed.
    localparam int            CW        = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    ptr;
    logic [2:0]    ptr_nxt;
    logic [2:0]    sel_nxt;
    logic [7:0]    gnt_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic [2:0]    search_base;
    logic          found;
    logic [2:0]    winner;
    logic          burst_done;
    logic          release_now;

    // First set bit of r at index base, base+1, ... (mod 8).
    // The loop walks from the farthest offset down to offset 0, so the nearest
    // hit is the last one assigned and wins.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            idx = base + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    // Datapath output and beat qualifier are purely combinational.
    assign dout  = din[32'(sel) * DW +: DW];
    assign valid = (state == GRANT) && req[sel];

    assign burst_done  = valid && (cnt == LAST_BEAT);
    assign release_now = (state == GRANT) && (!req[sel] || burst_done);

    // While granting, the only time the search result is used is on release,
    // and then the search must already use the advanced pointer (sel + 1).
    assign search_base       = (state == GRANT) ? (sel + 3'd1) : ptr;
    assign {found, winner}   = rr_pick(req, search_base);

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    sel_nxt   = winner;
                    gnt_nxt   = onehot8(winner);
                    cnt_nxt   = '0;
                end
            end

            GRANT: begin
                if (release_now) begin
                    ptr_nxt = sel + 3'd1;
                    cnt_nxt = '0;
                    if (found) begin
                        // Includes re-granting the same requester when it is
                        // the only one still asking.
                        sel_nxt = winner;
                        gnt_nxt = onehot8(winner);
                    end else begin
                        // sel keeps pointing at the last granted requester.
                        state_nxt = IDLE;
                        gnt_nxt   = 8'h00;
                    end
                end else if (valid) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 3'd0;
            gnt   <= 8'h00;
            ptr   <= 3'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [63:0] din;

    logic [2:0]  sel;
    logic [7:0]  gnt;
    logic [7:0]  dout;
    logic        valid;

    logic [2:0]  sel_b1;
    logic [7:0]  gnt_b1;
    logic [7:0]  dout_b1;
    logic        valid_b1;

    int vectors     = 0;
    int miscompares = 0;

    // Expected results, packed as {gnt, sel, valid, dout}.
    logic [19:0] sbq[$];

    mux_rr_arbiter #(.DW(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .sel   (sel),
        .gnt   (gnt),
        .dout  (dout),
        .valid (valid)
    );

    mux_rr_arbiter #(.DW(8), .MAX_BURST(1)) dut_b1 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .sel   (sel_b1),
        .gnt   (gnt_b1),
        .dout  (dout_b1),
        .valid (valid_b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // din slice i is 8'hA0 | i, so dout must read back 8'hA0 | sel.
    function automatic logic [19:0] ex(input logic on, input logic [2:0] s, input logic v);
        logic [7:0] g;
        logic [7:0] d;
        g = on ? (8'b0000_0001 << s) : 8'h00;
        d = 8'hA0 | {5'b00000, s};
        return {g, s, v, d};
    endfunction

    // Drive one cycle of stimulus at the falling edge and record what the
    // outputs must show in that same cycle.
    task automatic drive(input logic [7:0] r, input logic rn, input logic [19:0] e);
        @(negedge clk);
        req   = r;
        rst_n = rn;
        sbq.push_back(e);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h00;
    endtask

    task automatic test_reset();
        logic [19:0] got, exp;
        logic [7:0]  rq[$];
        logic        rn[$];
        logic [19:0] eq[$];
        rq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        rn = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        eq = '{ex(0,0,0), ex(0,0,0), ex(0,0,0), ex(1,0,1), ex(1,0,1)};
        for (int i = 0; i < rq.size(); i++) begin
            drive(rq[i], rn[i], eq[i]);
            got = {gnt, sel, valid, dout};
            exp = sbq.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset[%0d] got gnt/sel/valid/dout=%h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [19:0] got, exp;
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            drive(8'h20, 1'b1, (i == 0) ? ex(0,0,0) : ex(1,5,1));
            got = {gnt, sel, valid, dout};
            exp = sbq.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL single[%0d] got gnt/sel/valid/dout=%h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_rotation();
        logic [19:0] got, exp;
        logic [19:0] eq[$];
        apply_reset();
        eq.push_back(ex(0,0,0));
        for (int k = 0; k < 9; k++)
            for (int b = 0; b < 4; b++)
                eq.push_back(ex(1, 3'(k % 8), 1));
        for (int i = 0; i < eq.size(); i++) begin
            drive(8'hFF, 1'b1, eq[i]);
            got = {gnt, sel, valid, dout};
            exp = sbq.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rotation[%0d] got gnt/sel/valid/dout=%h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [19:0] got, exp;
        logic [19:0] eq[$];
        apply_reset();
        eq.push_back(ex(0,0,0));
        for (int b = 0; b < 4; b++) eq.push_back(ex(1,0,1));
        for (int b = 0; b < 4; b++) eq.push_back(ex(1,7,1));
        for (int b = 0; b < 4; b++) eq.push_back(ex(1,0,1));
        for (int i = 0; i < eq.size(); i++) begin
            drive(8'h81, 1'b1, eq[i]);
            got = {gnt, sel, valid, dout};
            exp = sbq.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL wrap[%0d] got gnt/sel/valid/dout=%h required %h", i, got, exp);
            end
        end
    endtask

    // Requester 2 takes two beats (bit 0 toggles meanwhile and must not
    // matter), drops, and requester 6 follows with no gap. Then all requests
    // vanish and the block idles with sel parked on 6.
    task automatic test_drop();
        logic [19:0] got, exp;
        logic [7:0]  rq[$];
        logic [19:0] eq[$];
        apply_reset();
        rq = '{8'h44, 8'h44, 8'h45, 8'h40, 8'h40, 8'h00, 8'h00};
        eq = '{ex(0,0,0), ex(1,2,1), ex(1,2,1), ex(1,2,0), ex(1,6,1), ex(1,6,0), ex(0,6,0)};
        for (int i = 0; i < rq.size(); i++) begin
            drive(rq[i], 1'b1, eq[i]);
            got = {gnt, sel, valid, dout};
            exp = sbq.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL drop[%0d] got gnt/sel/valid/dout=%h required %h", i, got, exp);
            end
        end
    endtask

    // Requester 3 alone: first burst moves ptr to 4, second burst is cut by
    // reset during beat 3. With all requests high afterwards, the winner must
    // be 0 (ptr back at 0), not 4.
    task automatic test_midreset();
        logic [19:0] got, exp;
        logic [7:0]  rq[$];
        logic        rn[$];
        logic [19:0] eq[$];
        apply_reset();
        rq.push_back(8'h08); rn.push_back(1'b1); eq.push_back(ex(0,0,0));
        for (int b = 0; b < 6; b++) begin
            rq.push_back(8'h08); rn.push_back(1'b1); eq.push_back(ex(1,3,1));
        end
        rq.push_back(8'h08); rn.push_back(1'b0); eq.push_back(ex(1,3,1));
        rq.push_back(8'hFF); rn.push_back(1'b1); eq.push_back(ex(0,0,0));
        rq.push_back(8'hFF); rn.push_back(1'b1); eq.push_back(ex(1,0,1));
        for (int i = 0; i < rq.size(); i++) begin
            drive(rq[i], rn[i], eq[i]);
            got = {gnt, sel, valid, dout};
            exp = sbq.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL midreset[%0d] got gnt/sel/valid/dout=%h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_burst1();
        logic [19:0] got, exp;
        logic [19:0] eq[$];
        apply_reset();
        eq.push_back(ex(0,0,0));
        for (int k = 0; k < 10; k++) eq.push_back(ex(1, 3'(k % 8), 1));
        for (int i = 0; i < eq.size(); i++) begin
            drive(8'hFF, 1'b1, eq[i]);
            got = {gnt_b1, sel_b1, valid_b1, dout_b1};
            exp = sbq.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL burst1[%0d] got gnt/sel/valid/dout=%h required %h", i, got, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'hA0 | 8'(i);
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_drop();
        test_midreset();
        test_burst1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
